// File: rtl/onehot_event_collector.sv
// rtl/onehot_event_collector.sv - sticky capture of 32 event lines, round-robin serialised as channel indices
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   y_in       32 one-cycle event requests, one per channel
//   out_valid  out_idx holds a granted channel
//   out_ready  consumer accepts out_idx when out_valid && out_ready
//   out_idx    granted channel number 0..31
//   pending    sticky flags of events not yet granted
//   drop_cnt   saturating count of cycles that lost at least one event
module onehot_event_collector #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_idx,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [4:0]  ptr;
    logic [63:0] rot_wide;
    logic [31:0] rot;
    logic [4:0]  offset;
    logic [4:0]  sel;
    logic        load;
    logic [31:0] load_mask;
    logic [31:0] drops;

    // Rotate pending so that bit ptr lands at position 0; the lowest set bit
    // of the rotated vector is then the next channel in round-robin order.
    assign rot_wide = {pending, pending} >> ptr;
    assign rot      = rot_wide[31:0];

    always_comb begin
        offset = '0;
        for (int i = 31; i >= 0; i--) begin
            if (rot[i]) begin
                offset = 5'(i);
            end
        end
    end

    // 5-bit add wraps naturally back into 0..31.
    assign sel       = ptr + offset;
    assign load      = (!out_valid || out_ready) && (pending != '0);
    assign load_mask = load ? (32'd1 << sel) : 32'd0;

    // A request on the channel being granted this cycle is a fresh event,
    // so the granted bit is excluded from the drop test.
    assign drops = y_in & pending & ~load_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= '0;
            drop_cnt  <= '0;
        end else begin
            pending <= (pending & ~load_mask) | y_in;

            if (load) begin
                out_idx   <= sel;
                out_valid <= 1'b1;
                ptr       <= sel + 5'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if ((drops != '0) && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_onehot_event_collector.sv
// tb/tb_onehot_event_collector.sv - scoreboard bench for onehot_event_collector
module tb_onehot_event_collector;

    logic        clk;
    logic        rst_n;
    logic [31:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] pending;
    logic [7:0]  drop_cnt;

    int checks;
    int failures;
    int exp_q[$];

    onehot_event_collector #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Inputs change 2 time units after the rising edge; calling step()
    // lets the next rising edge capture the current inputs.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_and_drain(input logic [31:0] y, input int n);
        y_in = y;
        step();
        y_in = '0;
        repeat (n + 1) step();
        chk("drain_valid", out_valid, 0);
        chk("drain_pending", pending, 0);
    endtask

    // Monitor: every accepted index is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got idx %0d expected none", out_idx);
            end else begin
                chk("sb_idx", out_idx, exp_q.pop_front());
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        y_in      = 32'hFFFF_FFFF;
        out_ready = 1'b0;

        // 1. reset with all inputs asserted
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_valid", out_valid, 0);
            chk("rst_idx", out_idx, 0);
            chk("rst_pending", pending, 0);
            chk("rst_drop", drop_cnt, 0);
        end
        rst_n     = 1'b1;
        y_in      = '0;
        out_ready = 1'b1;
        step();

        // 2. single event, two-cycle latency
        exp_q.push_back(7);
        y_in = 32'h0000_0080;
        step();
        y_in = '0;
        chk("lat_t1_valid", out_valid, 0);
        chk("lat_t1_pending", pending, 32'h0000_0080);
        step();
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_t2_idx", out_idx, 7);
        step();
        chk("lat_t3_valid", out_valid, 0);
        chk("lat_t3_pending", pending, 0);

        // 3. round robin and wrap
        exp_q.push_back(0);
        exp_q.push_back(4);
        pulse_and_drain(32'h0000_0011, 2);
        exp_q.push_back(9);
        exp_q.push_back(2);
        pulse_and_drain(32'h0000_0204, 2);
        exp_q.push_back(31);
        exp_q.push_back(0);
        pulse_and_drain(32'h8000_0001, 2);

        // 4. backpressure
        out_ready = 1'b0;
        exp_q.push_back(3);
        exp_q.push_back(12);
        y_in = 32'h0000_1008;
        step();
        y_in = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_idx", out_idx, 3);
            chk("bp_pending", pending, 32'h0000_1000);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_rel_valid", out_valid, 1);
        chk("bp_rel_idx", out_idx, 12);
        step();
        chk("bp_end_valid", out_valid, 0);

        // 5. drops and saturation, output holding channel 3
        out_ready = 1'b0;
        exp_q.push_back(3);
        y_in = 32'h0000_0008;
        step();
        y_in = '0;
        step();
        chk("drop_hold_idx", out_idx, 3);
        y_in = 32'h0000_0020;
        step();
        y_in = '0;
        step();
        chk("drop_first_none", drop_cnt, 0);
        y_in = 32'h0000_0020;
        step();
        chk("drop_one", drop_cnt, 1);
        y_in = 32'h0000_0003;
        step();
        chk("drop_fresh", drop_cnt, 1);
        step();
        chk("drop_multi", drop_cnt, 2);
        chk("drop_pending", pending, 32'h0000_0023);

        // same-cycle grant of channel 5 plus a new request on it
        exp_q.push_back(5);
        out_ready = 1'b1;
        y_in      = 32'h0000_0020;
        step();
        chk("regrant_idx", out_idx, 5);
        chk("regrant_pending", pending, 32'h0000_0023);
        chk("regrant_drop", drop_cnt, 2);

        out_ready = 1'b0;
        y_in      = 32'h0000_0003;
        repeat (300) step();
        chk("sat_drop", drop_cnt, 255);
        y_in = '0;

        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(5);
        out_ready = 1'b1;
        repeat (4) step();
        chk("sat_drain_valid", out_valid, 0);
        chk("sat_drain_pending", pending, 0);
        chk("sat_hold", drop_cnt, 255);

        // 6. reset mid-operation
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        y_in      = 32'h0000_0004;
        step();
        y_in = 32'h00F0_0000;
        step();
        y_in = 32'h0010_0000;
        repeat (4) step();
        y_in = '0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_idx", out_idx, 2);
        chk("pre_rst_pending", pending, 32'h00F0_0000);
        chk("pre_rst_drop", drop_cnt, 4);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(20);
        y_in = 32'h0010_0000;
        step();
        y_in = '0;
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_idx", out_idx, 20);
        step();
        chk("post_rst_end", out_valid, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_event_collector.md
# onehot_event_collector

Downstream consumer of the 1:32 demultiplexer. It captures the 32 one-hot (or multi-hot) output lines into sticky pending flags. It then serialises them as 5-bit channel indices over a valid/ready interface, using round-robin priority. It also counts the cycles in which events were lost because a channel was already pending.

## Interface

Parameters:
- `CNT_W`, default 8: width of the saturating drop counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `y_in`, input, 32: demux outputs; each bit is a one-cycle event request for channel i.
- `out_valid`, output, 1: `out_idx` holds a granted channel.
- `out_ready`, input, 1: consumer accepts `out_idx` in a cycle where `out_valid && out_ready`.
- `out_idx`, output, 5: granted channel number, 0..31.
- `pending`, output, 32: sticky flags of events not yet granted.
- `drop_cnt`, output, CNT_W: saturating count of cycles with at least one dropped event.

## Operation

State:
- `pending[31:0]`
- output register (`out_valid`, `out_idx`)
- round-robin pointer `ptr[4:0]`
- `drop_cnt`

Reset (`rst_n` = 0 at a rising edge):
- `pending` = 0, `out_valid` = 0, `out_idx` = 0, `ptr` = 0, `drop_cnt` = 0.
- `y_in` is ignored in that cycle.

Load condition:
- `load` = `(!out_valid || out_ready) && (pending != 0)`.

Selection (combinational, on the registered `pending` only; never on the same-cycle `y_in`):
- `sel` = the first set bit of `pending` searching upward from `ptr` through 31, then wrapping to 0 .. `ptr`-1.

On load:
- `out_idx` <= `sel`, `out_valid` <= 1.
- `pending[sel]` is cleared.
- `ptr` <= `(sel + 1) mod 32`; 31 wraps to 0.

Consumer accepts with nothing to load:
- If `out_valid && out_ready && pending == 0`, then `out_valid` <= 0 and `out_idx` holds its last value.

Pending update:
- `pending_next = (pending & ~load_mask) | y_in`.
- `load_mask` is one-hot at `sel` when `load` is 1, otherwise 0.
- A `y_in[i]` that arrives in the same cycle `pending[i]` is granted re-sets `pending[i]`. This is a new event, not a drop.

Drop detection:
- Channel i drops when `y_in[i] && pending[i] && !load_mask[i]`.
- The index currently held in the output register does not count as pending.
- `drop_cnt` increments by 1 in any cycle with one or more drops, and saturates at `2^CNT_W - 1`.

Backpressure:
- While `out_valid && !out_ready`, `out_idx` and `out_valid` are held stable, `ptr` is unchanged, and `pending` only accumulates.

## Timing

- Latency: a `y_in[i]` pulse in cycle t sets `pending[i]` in t+1. If the output register is empty or being accepted, `out_valid` = 1 with `out_idx` = i in t+2.
- Throughput: one index per cycle while `out_ready` is held at 1.
- Outputs are all registered; there is no combinational path from `y_in` or `out_ready` to any output.
- Reset mid-operation discards any held output, all pending flags and the count. `out_valid` = 0 starting the cycle after the reset edge.

## Test plan

1. **Reset:** hold `rst_n` = 0 for 2 cycles with `y_in` = 32'hFFFF_FFFF.
   Required: `out_valid` = 0, `out_idx` = 0, `pending` = 0, `drop_cnt` = 0 after each edge.
2. **Single event:** pulse `y_in` = 32'h0000_0080 for one cycle, `out_ready` = 1.
   Required: `out_valid` = 1 with `out_idx` = 7 exactly two cycles later, for one cycle; `pending` = 0 afterwards.
3. **Round-robin and wrap:** pulse `y_in` = 32'h0000_0011 with `out_ready` = 1.
   Required: indices 0 then 4, leaving `ptr` = 5.
   Then pulse 32'h0000_0204. Required: 9 then 2.
   Then pulse 32'h8000_0001 once `ptr` = 3. Required: 31 then 0.
4. **Backpressure:** hold `out_ready` = 0 and pulse `y_in` bits 3 and 12.
   Required: `out_idx` = 3 stays stable with `out_valid` = 1 for 10 cycles, and `pending` = 32'h0000_1000.
   Release `out_ready`. Required: 12 follows on the next cycle.
5. **Drop and saturation:** with `out_ready` = 0 and the output holding channel 3, pulse `y_in[5]` twice, 2 cycles apart. Required: `drop_cnt` = 1.
   Pulse `y_in` = 32'h0000_0003 while both bits are already pending. Required: `drop_cnt` +1 only, not +2.
   Continue for 300 drop cycles. Required: `drop_cnt` = 255.
   Same-cycle grant plus new `y_in` on that channel: required `drop_cnt` unchanged and `pending` bit set.
6. **Reset mid-operation:** with `out_valid` = 1, `pending` = 32'h00F0_0000 and `drop_cnt` = 4, assert `rst_n` = 0 for one cycle.
   Required: all outputs 0 next cycle. A new pulse on bit 20 afterwards yields `out_idx` = 20 two cycles later.
